// File: rtl/mul_repadd_pkg.sv
// Shared types and defaults for the repeated-addition multiplier controller.
package mul_repadd_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mul_operand_sel.sv
// Operand capture register with optional unsigned ordering, so the smaller
// operand becomes the iteration count and the add loop stays short.
module mul_operand_sel
  import mul_repadd_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned SWAP_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] mcount
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mcount_q, mcount_d;

  always_comb begin
    mcand_d  = mcand_q;
    mcount_d = mcount_q;
    if (capture) begin
      // A tie keeps the original order.
      if ((SWAP_EN != 0) && (op_a < op_b)) begin
        mcand_d  = op_b;
        mcount_d = op_a;
      end else begin
        mcand_d  = op_a;
        mcount_d = op_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mcount_q <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mcount_q <= mcount_d;
    end
  end

  assign mcand  = mcand_q;
  assign mcount = mcount_q;

endmodule

// File: rtl/mul_repadd_ctrl.sv
// Control FSM for the repeated-addition multiplier: loads A and B over the
// shared bus, clears P, then adds A into P until the B counter reaches zero.
module mul_repadd_ctrl
  import mul_repadd_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned SWAP_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             eqz,
  output logic [WIDTH-1:0] data_in,
  output logic             LdA,
  output logic             LdB,
  output logic             LdP,
  output logic             clrP,
  output logic             decB,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic             capture;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mcount;

  assign capture = (state_q == IDLE) && start;

  mul_operand_sel #(
    .WIDTH  (WIDTH),
    .SWAP_EN(SWAP_EN)
  ) u_operand_sel (
    .clk    (clk),
    .rst    (rst),
    .capture(capture),
    .op_a   (op_a),
    .op_b   (op_b),
    .mcand  (mcand),
    .mcount (mcount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = CALC;
      CALC:    if (eqz) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // eqz only matters in CALC; every other state decodes without it.
  always_comb begin
    data_in = '0;
    LdA     = 1'b0;
    LdB     = 1'b0;
    LdP     = 1'b0;
    clrP    = 1'b0;
    decB    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      LOAD_A: begin
        data_in = mcand;
        LdA     = 1'b1;
        busy    = 1'b1;
      end
      LOAD_B: begin
        data_in = mcount;
        LdB     = 1'b1;
        clrP    = 1'b1;
        busy    = 1'b1;
      end
      CALC: begin
        busy = 1'b1;
        if (!eqz) begin
          LdP  = 1'b1;
          decB = 1'b1;
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_repadd_ctrl.sv
// Scoreboard bench: two controllers (SWAP_EN = 0 and 1), each driving its own
// behavioural datapath; a monitor checks bus values, add counts, latency and P.
module tb_mul_repadd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] op_a, op_b;
  logic [1:0]  start_w;
  logic [1:0]  eqz_w, lda_w, ldb_w, ldp_w, clrp_w, decb_w, busy_w, done_w;
  logic [15:0] bus_w [2];
  logic [15:0] p_w   [2];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    int          inst;
    logic [15:0] bus_a;
    logic [15:0] bus_b;
    int          adds;
    int          lat;
    logic [15:0] p;
    int          gap;
  } exp_t;

  exp_t sb[$];

  int add_cnt[2], lda_cnt[2], start_cyc[2], last_done[2], done_cnt[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0 has SWAP_EN = 0, instance 1 has SWAP_EN = 1.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [15:0] a_m = '0;
    logic [15:0] b_m = '0;
    logic [15:0] p_m = '0;

    mul_repadd_ctrl #(
      .WIDTH  (16),
      .SWAP_EN(gi)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start_w[gi]),
      .op_a   (op_a),
      .op_b   (op_b),
      .eqz    (eqz_w[gi]),
      .data_in(bus_w[gi]),
      .LdA    (lda_w[gi]),
      .LdB    (ldb_w[gi]),
      .LdP    (ldp_w[gi]),
      .clrP   (clrp_w[gi]),
      .decB   (decb_w[gi]),
      .busy   (busy_w[gi]),
      .done   (done_w[gi])
    );

    always @(posedge clk) begin
      if (lda_w[gi]) a_m <= bus_w[gi];
      if (ldb_w[gi]) b_m <= bus_w[gi];
      else if (decb_w[gi]) b_m <= b_m - 16'd1;
      if (clrp_w[gi]) p_m <= '0;
      else if (ldp_w[gi]) p_m <= p_m + a_m;
    end

    assign eqz_w[gi] = (b_m == 16'd0);
    assign p_w[gi]   = p_m;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ((lda_w[i] & ldb_w[i]) | (clrp_w[i] & ldp_w[i])) begin
        fails++;
        $display("FAIL strobe_excl[%0d]: LdA=%0b LdB=%0b clrP=%0b LdP=%0b, required no overlap",
                 i, lda_w[i], ldb_w[i], clrp_w[i], ldp_w[i]);
      end
      if (rst) begin
        add_cnt[i] = 0;
        lda_cnt[i] = 0;
        continue;
      end
      if (lda_w[i]) begin
        lda_cnt[i]++;
        start_cyc[i] = cyc;
        if (sb.size() > 0 && sb[0].inst == i) begin
          chk($sformatf("bus_a[%0d]", i), bus_w[i], sb[0].bus_a);
          if (sb[0].gap >= 0 && lda_cnt[i] == 1)
            chk($sformatf("idle_gap[%0d]", i), cyc - last_done[i], sb[0].gap);
        end
      end
      if (ldb_w[i]) begin
        chk($sformatf("clrP_with_LdB[%0d]", i), clrp_w[i], 1);
        if (sb.size() > 0 && sb[0].inst == i)
          chk($sformatf("bus_b[%0d]", i), bus_w[i], sb[0].bus_b);
      end
      if (ldp_w[i]) begin
        add_cnt[i]++;
        chk($sformatf("decB_with_LdP[%0d]", i), decb_w[i], 1);
      end
      if (done_w[i]) begin
        done_cnt[i]++;
        if (sb.size() == 0 || sb[0].inst != i) begin
          fails++;
          $display("FAIL unexpected_done[%0d]: done pulsed with no operation pending (cycle %0d)", i, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("product[%0d]", i), p_w[i], e.p);
          chk($sformatf("add_cycles[%0d]", i), add_cnt[i], e.adds);
          chk($sformatf("latency[%0d]", i), cyc - start_cyc[i] + 1, e.lat);
          chk($sformatf("lda_count[%0d]", i), lda_cnt[i], 1);
          chk($sformatf("busy_in_done[%0d]", i), busy_w[i], 1);
          $display("op inst=%0d P=%0d adds=%0d latency=%0d", i, p_w[i], add_cnt[i],
                   cyc - start_cyc[i] + 1);
        end
        last_done[i] = cyc;
        add_cnt[i]   = 0;
        lda_cnt[i]   = 0;
      end
    end
  end

  // lat counts cycles from the LdA cycle through the done cycle inclusive (4 + N).
  task automatic push(input int inst, input logic [15:0] ea, input logic [15:0] eb,
                      input int adds, input int lat, input logic [15:0] p, input int gap);
    exp_t e;
    e.inst = inst; e.bus_a = ea; e.bus_b = eb; e.adds = adds; e.lat = lat; e.p = p; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic launch(input int inst, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op_a = a;
    op_b = b;
    start_w[inst] = 1'b1;
    @(negedge clk);
    start_w[inst] = 1'b0;
    op_a = 16'($urandom);
    op_b = 16'($urandom);
  endtask

  task automatic wait_done(input int inst);
    bit seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done_w[inst]) seen = 1;
    end
    chk($sformatf("done_seen[%0d]", inst), seen, 1);
  endtask

  task automatic wait_ldp(input int inst);
    bit seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (ldp_w[inst]) seen = 1;
    end
    chk($sformatf("ldp_seen[%0d]", inst), seen, 1);
  endtask

  task automatic run_op(input int inst, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ea, input logic [15:0] eb,
                        input int adds, input int lat, input logic [15:0] p);
    push(inst, ea, eb, adds, lat, p, -1);
    launch(inst, a, b);
    wait_done(inst);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_quiet(input string name, input int i);
    chk({name, "_ctl"}, {busy_w[i], done_w[i], lda_w[i], ldb_w[i], ldp_w[i], clrp_w[i], decb_w[i]}, 0);
    chk({name, "_bus"}, bus_w[i], 0);
  endtask

  initial begin
    int dc;
    rst = 1'b1;
    start_w = '0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(negedge clk);
    chk_quiet("reset0", 0);
    chk_quiet("reset1", 1);
    rst = 1'b0;

    // 7x3 with swap enabled
    run_op(1, 16'd7, 16'd3, 16'd7, 16'd3, 3, 7, 16'd21);
    // 2x9: swapped vs not swapped
    run_op(1, 16'd2, 16'd9, 16'd9, 16'd2, 2, 6, 16'd18);
    run_op(0, 16'd2, 16'd9, 16'd2, 16'd9, 9, 13, 16'd18);
    // zero multiplier
    run_op(1, 16'd5, 16'd0, 16'd5, 16'd0, 0, 4, 16'd0);
    run_op(1, 16'd0, 16'd0, 16'd0, 16'd0, 0, 4, 16'd0);
    run_op(0, 16'd5, 16'd0, 16'd5, 16'd0, 0, 4, 16'd0);
    run_op(0, 16'd7, 16'd3, 16'd7, 16'd3, 3, 7, 16'd21);

    // start pulsed during CALC is ignored
    push(1, 16'd6, 16'd4, 4, 8, 16'd24, -1);
    launch(1, 16'd4, 16'd6);
    wait_ldp(1);
    start_w[1] = 1'b1;
    @(negedge clk);
    start_w[1] = 1'b0;
    wait_done(1);
    repeat (4) @(negedge clk);

    // start held high: second op after one IDLE cycle
    push(1, 16'd5, 16'd3, 3, 7, 16'd15, -1);
    push(1, 16'd5, 16'd3, 3, 7, 16'd15, 2);
    @(negedge clk);
    op_a = 16'd3;
    op_b = 16'd5;
    start_w[1] = 1'b1;
    wait_done(1);
    @(negedge clk);
    @(negedge clk);
    start_w[1] = 1'b0;
    wait_done(1);
    repeat (2) @(negedge clk);

    // reset during CALC aborts 10x10
    launch(1, 16'd10, 16'd10);
    wait_ldp(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("abort", 1);
    rst = 1'b0;
    dc = done_cnt[1];
    repeat (30) @(negedge clk);
    chk("no_done_after_abort", done_cnt[1], dc);
    run_op(1, 16'd3, 16'd3, 16'd3, 16'd3, 3, 7, 16'd9);

    // wrap-around
    run_op(1, 16'hFFFF, 16'd2, 16'hFFFF, 16'd2, 2, 6, 16'hFFFE);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
    $fatal(1);
  end

endmodule
